// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, bundle type and slot-ordering helpers.
// Slot 0 always sits in the most significant lane of a flat bus.
package fetch_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int INSTR_W     = 16;
    localparam int PC_W        = 16;
    localparam int WADDR_W     = 15;
    localparam int IFLAT_W     = FETCH_WIDTH * INSTR_W;
    localparam int AFLAT_W     = FETCH_WIDTH * WADDR_W;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [FETCH_WIDTH-1:0][INSTR_W-1:0] instr_vec_t;

    typedef struct packed {
        pc_t        pc;
        instr_vec_t instr;
    } fetch_bundle_t;

    function automatic instr_vec_t unflatten_instr(
        input logic [IFLAT_W-1:0] flat
    );
        instr_vec_t v;
        v = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            v[k] = flat[(FETCH_WIDTH-1-k)*INSTR_W +: INSTR_W];
        return v;
    endfunction

    function automatic logic [IFLAT_W-1:0] flatten_instr(
        input instr_vec_t v
    );
        logic [IFLAT_W-1:0] f;
        f = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            f[(FETCH_WIDTH-1-k)*INSTR_W +: INSTR_W] = v[k];
        return f;
    endfunction

    // Consecutive halfword addresses; wraps naturally at 2^15.
    function automatic logic [AFLAT_W-1:0] slot_addrs(
        input waddr_t base
    );
        logic [AFLAT_W-1:0] f;
        f = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            f[(FETCH_WIDTH-1-k)*WADDR_W +: WADDR_W] = base + waddr_t'(k);
        return f;
    endfunction

endpackage

// File: rtl/fetch_bundle_fifo.sv
// fetch_bundle_fifo: small bundle buffer between cache and decode.
// Synchronous flush beats push; callers never push into a full buffer.
module fetch_bundle_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_bundle_t    push_data,
    input  logic             pop,
    output fetch_bundle_t    head,
    output logic [CNT_W-1:0] count
);

    fetch_bundle_t    mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; the head slot is never the write target while occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: issues 4-wide cache reads, tracks the 1-cycle
// response and buffers bundles for decode; redirects flush everything.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [59:0] pc_array_flat,
    input  logic [63:0] instructions_flat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [63:0] out_instructions_flat
);

    localparam int  CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam pc_t RESET_FETCH = RESET_PC & 16'hFFFE;

    pc_t             fetch_pc_q;
    pc_t             inflight_pc_q;
    logic            inflight_valid_q;
    pc_t             cur_pc;
    logic            pop;
    logic            issue;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]  occupancy;
    fetch_bundle_t   rsp_bundle;
    fetch_bundle_t   head;

    // Address source for this cycle: a redirect overrides the running PC.
    always_comb begin
        cur_pc        = redirect_valid ? (redirect_pc & 16'hFFFE) : fetch_pc_q;
        pc_array_flat = slot_addrs(cur_pc[15:1]);
    end

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;

    // Credit check: buffered + in flight, less what leaves this cycle.
    assign occupancy = (CNT_W+1)'(fifo_count)
                     + (CNT_W+1)'(inflight_valid_q)
                     - (CNT_W+1)'(pop);
    assign issue     = redirect_valid
                     | (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // PC and in-flight tracking; the cache read latency is one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q       <= RESET_FETCH;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
        end else begin
            inflight_valid_q <= issue;
            if (issue) begin
                inflight_pc_q <= cur_pc;
                fetch_pc_q    <= cur_pc + 16'd8;
            end
        end
    end

    // Response bundle captured as the cache data arrives.
    always_comb begin
        rsp_bundle       = '0;
        rsp_bundle.pc    = inflight_pc_q;
        rsp_bundle.instr = unflatten_instr(instructions_flat);
    end

    fetch_bundle_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (inflight_valid_q),
        .push_data (rsp_bundle),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Head is shown only while valid so idle outputs read as zero.
    always_comb begin
        out_pc                = '0;
        out_instructions_flat = '0;
        if (out_valid) begin
            out_pc                = head.pc;
            out_instructions_flat = flatten_instr(head.instr);
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios with a stream-level model
// of the fetch output plus hand-computed literal expectations.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [59:0] pc_array_flat;
    logic [63:0] instructions_flat = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_pc;
    logic [63:0] out_instructions_flat;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .pc_array_flat         (pc_array_flat),
        .instructions_flat     (instructions_flat),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_pc                (out_pc),
        .out_instructions_flat (out_instructions_flat)
    );

    always #5 clk = ~clk;

    // Memory image: each halfword address holds a distinct word.
    function automatic logic [15:0] img(input logic [14:0] a);
        return {a, 1'b1} ^ 16'hC3A5;
    endfunction

    function automatic logic [63:0] cache_read(input logic [59:0] addrs);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 4; k++)
            d[63-16*k -: 16] = img(addrs[59-15*k -: 15]);
        return d;
    endfunction

    function automatic logic [59:0] exp_addrs(input logic [15:0] pc);
        logic [59:0] a;
        logic [14:0] w;
        a = '0;
        for (int k = 0; k < 4; k++) begin
            w = pc[15:1] + 15'(k);
            a[59-15*k -: 15] = w;
        end
        return a;
    endfunction

    function automatic logic [63:0] exp_bundle(input logic [15:0] pc);
        return cache_read(exp_addrs(pc));
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Cache model: addresses seen in one cycle answer in the next.
    logic [59:0] cache_addr;
    always begin
        @(negedge clk);
        cache_addr = pc_array_flat;
        @(posedge clk);
        #1 instructions_flat = cache_read(cache_addr);
    end

    // Stream model: in-order PCs from the latest start, valid from start+2.
    logic [15:0] exp_pc = 16'h0000;
    int          since = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_valid", out_valid, 0);
            chk("reset_pc", out_pc, 0);
            chk("reset_instr", out_instructions_flat, 0);
            exp_pc = 16'h0000;
            since  = 0;
        end else begin
            since++;
            chk("valid", out_valid, since >= 2);
            if (out_valid) begin
                chk("head_pc", out_pc, exp_pc);
                chk("head_instr", out_instructions_flat, exp_bundle(exp_pc));
            end
            if (out_valid && out_ready)
                exp_pc = exp_pc + 16'd8;
            if (redirect_valid) begin
                chk("redirect_addrs", pc_array_flat,
                    exp_addrs(redirect_pc & 16'hFFFE));
                exp_pc = redirect_pc & 16'hFFFE;
                since  = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset release and streaming from PC 0
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("s1_addrs", pc_array_flat, {15'h0, 15'h1, 15'h2, 15'h3});
        step(1);
        chk("s1_gap", out_valid, 0);
        step(1);
        chk("s1_first_valid", out_valid, 1);
        chk("s1_first_pc", out_pc, 16'h0000);
        chk("s1_first_data", out_instructions_flat, 64'hC3A4_C3A6_C3A0_C3A2);
        step(1);
        chk("s1_second_pc", out_pc, 16'h0008);
        step(3);

        // 2: decode stalls six cycles
        out_ready = 1'b0;
        step(5);
        chk("s2_hold_pc", out_pc, 16'h0020);
        step(1);
        out_ready = 1'b1;
        step(1);
        chk("s2_resume_pc", out_pc, 16'h0028);
        step(1);
        chk("s2_no_gap", out_valid, 1);
        chk("s2_next_pc", out_pc, 16'h0030);
        step(1);

        // 3: redirect to an odd byte PC
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1235;
        #1 chk("s3_addrs", pc_array_flat,
               {15'h091A, 15'h091B, 15'h091C, 15'h091D});
        step(1);
        redirect_valid = 1'b0;
        chk("s3_flushed", out_valid, 0);
        step(1);
        chk("s3_new_pc", out_pc, 16'h1234);
        step(2);

        // 4: redirect near the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        #1 chk("s4_addrs", pc_array_flat,
               {15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001});
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("s4_pc", out_pc, 16'hFFFC);
        chk("s4_data", out_instructions_flat, 64'h3C58_3C5A_C3A4_C3A6);
        step(1);
        chk("s4_wrap_pc", out_pc, 16'h0004);

        // back-to-back redirects: only the second target appears
        redirect_valid = 1'b1;
        redirect_pc    = 16'h4000;
        step(1);
        redirect_pc    = 16'h5002;
        step(1);
        redirect_valid = 1'b0;
        chk("b2b_gap", out_valid, 0);
        step(1);
        chk("b2b_pc", out_pc, 16'h5002);
        step(1);

        // 5: full buffer, redirect together with a handshake
        out_ready = 1'b0;
        step(4);
        chk("s5_held_pc", out_pc, 16'h500A);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h2468;
        step(1);
        redirect_valid = 1'b0;
        chk("s5_flushed", out_valid, 0);
        step(1);
        chk("s5_new_pc", out_pc, 16'h2468);
        step(1);
        chk("s5_next_pc", out_pc, 16'h2470);
        step(2);

        // 6: asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1 chk("s6_async_valid", out_valid, 0);
        step(2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("s6_addrs", pc_array_flat, {15'h0, 15'h1, 15'h2, 15'h3});
        step(1);
        chk("s6_gap", out_valid, 0);
        step(1);
        chk("s6_first_pc", out_pc, 16'h0000);
        chk("s6_first_valid", out_valid, 1);
        step(1);
        chk("s6_second_pc", out_pc, 16'h0008);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the 4-wide instruction cache. Each cycle it issues four consecutive halfword addresses and tracks the cache's fixed 1-cycle read latency. It buffers returned bundles in a small FIFO so decode can apply backpressure without losing or duplicating bundles. It also handles front-end redirects (branch or exception flush) and sits between the PC logic and the decode stage.

Parameters:
RESET_PC, 16'h0000, byte PC fetched first after reset (bit 0 ignored)
FIFO_DEPTH, 2, output bundle buffer entries; minimum 2, which is required for full throughput

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  16  new byte PC; bit 0 ignored
pc_array_flat  out  60  to cache; slot0 = [59:45], slot1 = [44:30], slot2 = [29:15], slot3 = [14:0]; 15-bit halfword addresses
instructions_flat  in  64  from cache, 1 cycle after address; slot0 = [63:48] ... slot3 = [15:0]
out_valid  out  1  bundle available to decode
out_ready  in  1  decode accepts bundle
out_pc  out  16  byte PC of slot0 of the head bundle (bit 0 = 0)
out_instructions_flat  out  64  head bundle, same slot ordering as instructions_flat

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert):
  - fetch_pc = RESET_PC & ~1.
  - inflight_valid = 0, FIFO empty, so out_valid = 0.
  - out_pc and out_instructions_flat = 0.
- Address generation: base = fetch_pc[15:1]; slot k address = (base + k) mod 2^15, for k = 0..3. Wrap 0x7FFF to 0x0000 within a bundle and across bundles.
- pc_array_flat is driven combinationally every cycle. The cache always reads; only the issue decision is tracked.
- Issue condition: (fifo_count - pop + inflight_valid) < FIFO_DEPTH, where pop = out_valid & out_ready.
- On issue:
  - inflight_valid <= 1, inflight_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 8 (mod 2^16).
- On no issue: inflight_valid <= 0 and fetch_pc holds.
- Response: a cycle with inflight_valid = 1 pushes {inflight_pc, instructions_flat} into the FIFO at the end of that cycle.
- Latency: issue in cycle T gives out_valid in cycle T+2. There is no bypass.
- Throughput: one bundle per cycle while out_ready = 1.
- Handshake:
  - Head is popped when out_valid & out_ready.
  - out_valid, out_pc and out_instructions_flat stay stable while out_valid & !out_ready.
  - Bundles are delivered in issue order, with no loss or duplication.
- Full FIFO with pop and push in the same cycle: legal; count is unchanged.
- Redirect (cycle T), which has priority over everything else:
  - A handshake occurring in cycle T still completes; that head is consumed exactly once.
  - All remaining FIFO entries and the in-flight response are discarded.
  - Addresses driven in cycle T come from redirect_pc; inflight_valid <= 1, inflight_pc <= redirect_pc & ~1, fetch_pc <= (redirect_pc & ~1) + 8.
  - The first new bundle appears at T+2. No pre-redirect bundle is visible from T+1 onward, so out_valid = 0 at T+1.
- Back-to-back redirects: the latest one wins; earlier targets never reach the output.
- Reset asserted mid-operation: all state is cleared immediately (async). The first issue occurs in the first clock edge after deassertion.

Decomposition:
- Shared package fetch_pkg:
  - FETCH_WIDTH = 4, INSTR_W = 16, PC_W = 16, WADDR_W = 15.
  - Bundle struct {pc, instr[4]}.
  - Flatten/unflatten slot-ordering helpers.
- One sub-module: fetch_bundle_fifo. It is a parameterized-depth FIFO with a synchronous flush and a count output; flush takes priority over push.
- Issue/credit logic and the PC register stay in fetch_controller.

Test Plan:
1. Reset release, RESET_PC = 0, out_ready = 1 -> issue-cycle addresses 0,1,2,3. out_valid rises 2 cycles later with out_pc 0x0000, then 0x0008, 0x0010, ... every cycle, with data matching the hex image.
2. out_ready = 0 for 6 cycles mid-stream -> head held stable, at most 2 bundles buffered, issue stops. After release, the sequence continues with no gap, loss or duplicate.
3. redirect_valid with redirect_pc = 0x1235 at T -> at T+1 out_valid = 0. At T+2 out_pc = 0x1234 and slot addresses were 0x091A-0x091D; no old bundles after T.
4. redirect_pc = 0xFFFC -> slot addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; next out_pc = 0x0004.
5. Full FIFO with redirect and out_valid & out_ready in the same cycle -> head consumed once, second entry and the in-flight response dropped, new target at T+2.
6. rst_n pulsed low mid-stream, asynchronously between edges -> out_valid = 0 immediately; after release the fetch restarts at RESET_PC with the same latency as scenario 1.
